// File: rtl/mdc_pack_pkg.sv
// Shared definitions for the FIFO read-side packer.
//   state_t : packer state encoding (COLLECT gathers tokens, HOLD presents a word)
//   cnt_w   : counter width for a modulo-n count, never narrower than 1 bit
package mdc_pack_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic int cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mdc_mod_counter.sv
// Modulo-N up-counter.
//   clk  : clock
//   rst  : asynchronous active-low reset (count -> 0)
//   clr  : synchronous clear (count -> 0), overrides inc
//   inc  : advance the count by one
//   cnt  : current count, 0..N-1
//   wrap : combinational, high when this increment rolls N-1 back to 0
module mdc_mod_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic at_max;

  assign at_max = (cnt == W'(N - 1));
  assign wrap   = inc & at_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_max ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/mdc_fifo_packer_rd.sv
// Read end of the shift-register FIFO: pops SIZE-bit tokens, packs PACK of
// them into one word (token 0 in the low bits) and hands the word downstream
// with valid/ready. Every ROWS-th word is tagged as the last of its frame.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   clr        : synchronous clear of the partial word and the frame position
//   fifo_valid : FIFO head token present on fifo_data
//   fifo_data  : FIFO head token
//   fifo_enr   : pop request (combinational)
//   dout       : packed word
//   dout_valid : dout holds a complete word
//   dout_last  : word closes its frame (qualified by dout_valid)
//   dout_ready : downstream accepts the word
//   frame_done : one-cycle pulse after the last word of a frame is accepted
module mdc_fifo_packer_rd
  import mdc_pack_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int PACK = 4,
  parameter int ROWS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 fifo_valid,
  input  logic [SIZE-1:0]      fifo_data,
  output logic                 fifo_enr,
  output logic [PACK*SIZE-1:0] dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  input  logic                 dout_ready,
  output logic                 frame_done
);

  localparam int TW = cnt_w(PACK);
  localparam int RW = cnt_w(ROWS);

  state_t        state;
  logic [TW-1:0] tok_cnt;
  logic          tok_wrap;
  logic [RW-1:0] row_cnt;
  logic          row_wrap;
  logic          pop;
  logic          accept;

  assign fifo_enr = rst & ~clr & (state == COLLECT) & fifo_valid;
  assign pop      = fifo_enr;
  // clr discards a held word, so an acceptance in a clr cycle does not count
  assign accept   = ~clr & (state == HOLD) & dout_valid & dout_ready;

  mdc_mod_counter #(.N(PACK), .W(TW)) u_tok_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (pop),
    .cnt  (tok_cnt),
    .wrap (tok_wrap)
  );

  mdc_mod_counter #(.N(ROWS), .W(RW)) u_row_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (accept),
    .cnt  (row_cnt),
    .wrap (row_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= COLLECT;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clr) begin
        state      <= COLLECT;
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end else if (state == COLLECT) begin
        if (pop) begin
          dout[int'(tok_cnt)*SIZE +: SIZE] <= fifo_data;
          if (tok_wrap) begin
            state      <= HOLD;
            dout_valid <= 1'b1;
            dout_last  <= (row_cnt == RW'(ROWS - 1));
          end
        end
      end else begin
        if (accept) begin
          state      <= COLLECT;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
          // row_cnt wrapping on this acceptance means the frame just closed
          frame_done <= row_wrap;
        end
      end
    end
  end

endmodule
